jtag_shift_master: RTL and testbench
====================================

// Module: jtag_shift_master
// PURPOSE
//  Synthesizable JTAG master; successor to the behavioural VPI TAP driver.
//  Executes RESET / TMS_SEQ / SCAN / SCAN_FLIP_TMS commands from a valid/ready cmd port.
//  Streams TDI words in, TDO words out; generates TCK by dividing clk.
//  Sits between a host bridge (UART/AXI debug) and the target TAP pins.
// PARAMETERS
//  DATA_W        32  width of wr_data/rd_data words, bits shifted LSB first
//  LEN_W         16  width of cmd_nbits; max 2**LEN_W-1 bits per command
//  TCK_HALF      4   clk cycles per TCK half period (>=1); TCK = clk/(2*TCK_HALF)
//  RESET_CYCLES  5   TCK cycles with TMS=1 for OP_RESET
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  enable     in   1       0: no new command accepted
//  cmd_valid  in   1       command offered
//  cmd_ready  out  1       command accepted when valid&ready
//  cmd_op     in   2       0 RESET, 1 TMS_SEQ, 2 SCAN, 3 SCAN_FLIP_TMS
//  cmd_nbits  in   LEN_W   bit count (ignored for RESET)
//  wr_valid   in   1       TDI/TMS data word offered
//  wr_ready   out  1       word consumed when valid&ready
//  wr_data    in   DATA_W  bits to shift, LSB first
//  rd_valid   out  1       captured TDO word available
//  rd_ready   in   1       host accepts rd_data
//  rd_data    out  DATA_W  captured TDO, LSB = first bit; unused upper bits 0
//  busy       out  1       command in progress
//  tck        out  1       JTAG clock
//  tms        out  1       JTAG mode select
//  tdi        out  1       JTAG data to target
//  tdo        in   1       JTAG data from target (pre-synchronised by top level)
// BEHAVIOUR
//  Reset: tck=0 tms=0 tdi=0 cmd_ready=0 wr_ready=0 rd_valid=0 rd_data=0 busy=0; FSM IDLE.
//  States: IDLE, FETCH, LOW, HIGH, PUSH, FINISH.
//  IDLE: cmd_ready=enable. Accept -> latch op/nbits, busy=1; nbits=0 (non-RESET) -> FINISH.
//  FETCH: wr_ready=1 until a word is taken; tck held low meanwhile (stall).
//  LOW: drive tms/tdi for current bit at entry; TCK_HALF clks; tck rises -> HIGH.
//  HIGH: sample tdo into capture bit on the clk that raises tck; TCK_HALF clks; tck falls.
//   tdo is bit-indexed by count mod DATA_W; no sampling for RESET/TMS_SEQ.
//  Bit order: bit k of command = wr word k/DATA_W, bit k%DATA_W.
//  After a word's last bit or command's last bit: SCAN ops -> PUSH, else FETCH/FINISH.
//  PUSH: rd_data<=capture, rd_valid=1 held until rd_ready; if rd_valid still set from
//   previous word, wait (tck low). Capture register cleared after push.
//  RESET op: tms=1 for RESET_CYCLES TCKs then tms=0 one TCK (Run-Test/Idle); no wr/rd.
//  TMS_SEQ: wr bits drive tms; tdi unchanged.
//  SCAN_FLIP_TMS: tms=1 during final bit only (Exit1); SCAN: tms=0 throughout.
//  FINISH: tms=0, tdi=0, tck=0, busy=0 after one clk -> IDLE.
//  Output latency: first tck rise TCK_HALF clks after word accepted (LOW entry).
//  enable dropped mid-command: command completes; only new acceptance blocked.
//  cmd_valid with op while busy: not accepted (cmd_ready=0).
//  Async reset mid-command: immediate return to reset values; partial words discarded.
//  Bit counter LEN_W wide, counts down; no wrap. TCK_HALF counter $clog2(TCK_HALF+1).
// STRUCTURE
//  Package jtag_shift_pkg: OP_RESET/OP_TMS_SEQ/OP_SCAN/OP_SCAN_FLIP localparams,
//   FSM state encoding.
//  Sub-module jtag_tck_gen: half-period counter; run input, rise/fall strobes, tck out;
//   tck held low and counter cleared when run=0.
// TESTING
//  RESET op, TCK_HALF=2 -> 5 tck pulses tms=1, 1 pulse tms=0, 24 clks total busy.
//  SCAN nbits=8 wr 0xA5, tdo loopback of tdi -> rd_data=0x000000A5, tms=0 throughout.
//  SCAN_FLIP nbits=40 wr 0x12345678,0xFF -> 2 rd words 0x12345678,0x000000FF; tms=1 on bit 39 only.
//  TMS_SEQ nbits=6 wr 0x1F -> tms sequence 1,1,1,1,1,0 at tck rises; no rd_valid.
//  Stall: rd_ready=0 during 64-bit SCAN -> tck frozen low after bit 63 until pop; no data lost.
//  rst_n asserted mid-SCAN -> all outputs reset values same cycle; next cmd runs clean.

Source files
------------

// File: rtl/jtag_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtag_shift_pkg
// Brief    : Opcodes, FSM encoding and pin-drive helper for jtag_shift_master.
// Revision : 1.0 - initial release
// ============================================================================
package jtag_shift_pkg;

    localparam logic [1:0] OP_RESET     = 2'd0;
    localparam logic [1:0] OP_TMS_SEQ   = 2'd1;
    localparam logic [1:0] OP_SCAN      = 2'd2;
    localparam logic [1:0] OP_SCAN_FLIP = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_FETCH  = 3'd1;
    localparam state_t c_ST_LOW    = 3'd2;
    localparam state_t c_ST_HIGH   = 3'd3;
    localparam state_t c_ST_PUSH   = 3'd4;
    localparam state_t c_ST_FINISH = 3'd5;

    // Returns {tms, tdi} for one bit; last_bit marks the final TCK of the command.
    function automatic logic [1:0] drive_bits(input logic [1:0] op, input logic bit_val,
                                              input logic last_bit, input logic tdi_now);
        logic [1:0] w_drv;
        case (op)
            OP_RESET:   w_drv = {~last_bit, tdi_now};
            OP_TMS_SEQ: w_drv = {bit_val, tdi_now};
            OP_SCAN:    w_drv = {1'b0, bit_val};
            default:    w_drv = {last_bit, bit_val};
        endcase
        return w_drv;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tck_gen.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tck_gen
// Brief    : Divides clk into TCK; strobes mark the clk edge where TCK toggles.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tck_gen #(
    parameter int TCK_HALF = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    output logic o_rise,
    output logic o_fall,
    output logic o_tck
);

    localparam int c_CNT_W = $clog2(TCK_HALF + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_tck;
    logic               w_terminal;

    assign w_terminal = (r_cnt == c_CNT_W'(TCK_HALF - 1));
    assign o_rise     = i_run & w_terminal & ~r_tck;
    assign o_fall     = i_run & w_terminal &  r_tck;
    assign o_tck      = r_tck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (!i_run) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (w_terminal) begin
            r_cnt <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtag_shift_master.sv
`default_nettype none
// ============================================================================
// Module   : jtag_shift_master
// Brief    : Command-driven JTAG master streaming TDI words out and TDO words in.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_shift_master
    import jtag_shift_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 16,
    parameter int TCK_HALF     = 4,
    parameter int RESET_CYCLES = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_nbits,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
);

    localparam int c_IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t              r_state;
    logic [1:0]          r_op;
    logic [LEN_W-1:0]    r_bits_left;
    logic [c_IDX_W-1:0]  r_bit_idx;
    logic [DATA_W-1:0]   r_word;
    logic [DATA_W-1:0]   r_capture;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_cmd_ready;
    logic                r_wr_ready;
    logic                r_rd_valid;
    logic                r_busy;
    logic                r_tms;
    logic                r_tdi;

    logic                w_run;
    logic                w_rise;
    logic                w_fall;
    logic                w_last;
    logic                w_word_end;
    logic [c_IDX_W-1:0]  w_next_idx;

    assign w_run      = (r_state == c_ST_LOW) || (r_state == c_ST_HIGH);
    assign w_last     = (r_bits_left == LEN_W'(1));
    assign w_word_end = (r_op != OP_RESET) && (r_bit_idx == c_IDX_W'(DATA_W - 1));
    assign w_next_idx = r_bit_idx + 1'b1;

    assign cmd_ready = r_cmd_ready;
    assign wr_ready  = r_wr_ready;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign busy      = r_busy;
    assign tms       = r_tms;
    assign tdi       = r_tdi;

    jtag_tck_gen #(
        .TCK_HALF (TCK_HALF)
    ) u_tck_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_run  (w_run),
        .o_rise (w_rise),
        .o_fall (w_fall),
        .o_tck  (tck)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_op        <= OP_RESET;
            r_bits_left <= '0;
            r_bit_idx   <= '0;
            r_word      <= '0;
            r_capture   <= '0;
            r_rd_data   <= '0;
            r_cmd_ready <= 1'b0;
            r_wr_ready  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_tms       <= 1'b0;
            r_tdi       <= 1'b0;
        end else begin
            if (r_rd_valid && rd_ready) begin
                r_rd_valid <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_cmd_ready <= enable;
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_op        <= cmd_op;
                        r_bit_idx   <= '0;
                        r_capture   <= '0;
                        if (cmd_op == OP_RESET) begin
                            // RESET needs no data words: go straight to clocking TMS high.
                            r_bits_left    <= LEN_W'(RESET_CYCLES + 1);
                            {r_tms, r_tdi} <= drive_bits(OP_RESET, 1'b0, 1'b0, r_tdi);
                            r_state        <= c_ST_LOW;
                        end else begin
                            r_bits_left <= cmd_nbits;
                            if (cmd_nbits == '0) begin
                                r_state <= c_ST_FINISH;
                            end else begin
                                r_wr_ready <= 1'b1;
                                r_state    <= c_ST_FETCH;
                            end
                        end
                    end
                end

                c_ST_FETCH: begin
                    if (wr_valid && r_wr_ready) begin
                        r_wr_ready     <= 1'b0;
                        r_word         <= wr_data;
                        {r_tms, r_tdi} <= drive_bits(r_op, wr_data[0], w_last, r_tdi);
                        r_state        <= c_ST_LOW;
                    end
                end

                c_ST_LOW: begin
                    if (w_rise) begin
                        if (r_op[1]) begin
                            r_capture[r_bit_idx] <= tdo;
                        end
                        r_state <= c_ST_HIGH;
                    end
                end

                c_ST_HIGH: begin
                    if (w_fall) begin
                        r_bits_left <= r_bits_left - 1'b1;
                        r_bit_idx   <= w_word_end ? '0 : w_next_idx;
                        if (r_op[1] && (w_last || w_word_end)) begin
                            r_state <= c_ST_PUSH;
                        end else if (w_last) begin
                            r_busy  <= 1'b0;
                            r_tms   <= 1'b0;
                            r_tdi   <= 1'b0;
                            r_state <= c_ST_FINISH;
                        end else if (w_word_end) begin
                            r_wr_ready <= 1'b1;
                            r_state    <= c_ST_FETCH;
                        end else begin
                            {r_tms, r_tdi} <= drive_bits(r_op, r_word[w_next_idx],
                                                         r_bits_left == LEN_W'(2), r_tdi);
                            r_state        <= c_ST_LOW;
                        end
                    end
                end

                c_ST_PUSH: begin
                    // Hold TCK low until the host has drained the previous word.
                    if (!r_rd_valid) begin
                        r_rd_data  <= r_capture;
                        r_rd_valid <= 1'b1;
                        r_capture  <= '0;
                        if (r_bits_left == '0) begin
                            r_busy  <= 1'b0;
                            r_tms   <= 1'b0;
                            r_tdi   <= 1'b0;
                            r_state <= c_ST_FINISH;
                        end else begin
                            r_wr_ready <= 1'b1;
                            r_state    <= c_ST_FETCH;
                        end
                    end
                end

                c_ST_FINISH: begin
                    r_busy  <= 1'b0;
                    r_tms   <= 1'b0;
                    r_tdi   <= 1'b0;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_shift_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_shift_master
// Brief    : Self-checking bench for jtag_shift_master against a bit-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_shift_master;

    localparam int DATA_W       = 32;
    localparam int LEN_W        = 16;
    localparam int TCK_HALF     = 2;
    localparam int RESET_CYCLES = 5;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [LEN_W-1:0]  cmd_nbits;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              tck;
    logic              tms;
    logic              tdi;
    logic              tdo;

    logic              tdo_inv;
    int                n_tests = 0;
    int                n_fail  = 0;
    int                busy_clks;
    bit                rd_en   = 1'b1;
    bit                rd_rand = 1'b0;
    bit                pend;
    logic [31:0]       wbuf[$];
    logic [31:0]       wq[$];
    logic [31:0]       rq[$];
    logic [1:0]        mq[$];

    assign tdo = tdi ^ tdo_inv;

    jtag_shift_master #(
        .DATA_W       (DATA_W),
        .LEN_W        (LEN_W),
        .TCK_HALF     (TCK_HALF),
        .RESET_CYCLES (RESET_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_nbits (cmd_nbits),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word source: a handshake seen at one negedge completes at the following posedge.
    initial begin
        wr_valid = 1'b0;
        wr_data  = '0;
        pend     = 1'b0;
        forever begin
            @(negedge clk);
            if (pend && wq.size() > 0) void'(wq.pop_front());
            if (wq.size() > 0) begin
                wr_valid = 1'b1;
                wr_data  = wq[0];
            end else begin
                wr_valid = 1'b0;
            end
            pend = wr_valid && wr_ready;
        end
    end

    initial begin
        rd_ready = 1'b0;
        forever begin
            @(negedge clk);
            rd_ready = rd_en && (!rd_rand || ($urandom_range(0, 1) == 1));
            if (rd_valid && rd_ready) rq.push_back(rd_data);
        end
    end

    always @(posedge tck) mq.push_back({tms, tdi});
    always @(negedge clk) if (busy === 1'b1) busy_clks++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input int nbits);
        int t;
        mq.delete();
        rq.delete();
        busy_clks = 0;
        if (op != 2'd0) foreach (wbuf[i]) wq.push_back(wbuf[i]);
        @(negedge clk);
        cmd_op    = op;
        cmd_nbits = LEN_W'(nbits);
        cmd_valid = 1'b1;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("cmd_accept", 64'(t < 100), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", 64'(t < 20000), 64'd1);
        t = 0;
        while (rd_valid === 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
    endtask

    // Expected pins and read words straight from the command rules.
    task automatic check_result(input logic [1:0] op, input int nbits, input logic inv);
        logic [1:0]  em[$];
        logic [31:0] er[$];
        logic [31:0] wv;
        logic [31:0] mask;
        logic        b;
        int          n;
        if (op == 2'd0) begin
            for (int i = 0; i < RESET_CYCLES; i++) em.push_back(2'b10);
            em.push_back(2'b00);
        end else begin
            for (int k = 0; k < nbits; k++) begin
                wv = wbuf[k / 32];
                b  = wv[k % 32];
                case (op)
                    2'd1:    em.push_back({b, 1'b0});
                    2'd2:    em.push_back({1'b0, b});
                    default: em.push_back({(k == nbits - 1), b});
                endcase
            end
        end
        if (op[1]) begin
            for (int w = 0; w < (nbits + 31) / 32; w++) begin
                n    = nbits - 32 * w;
                if (n > 32) n = 32;
                mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
                er.push_back((wbuf[w] ^ {32{inv}}) & mask);
            end
        end
        check("tck_pulses", 64'(mq.size()), 64'(em.size()));
        for (int i = 0; i < em.size() && i < mq.size(); i++)
            check($sformatf("tms_tdi_bit%0d", i), 64'(mq[i]), 64'(em[i]));
        check("rd_words", 64'(rq.size()), 64'(er.size()));
        for (int i = 0; i < er.size() && i < rq.size(); i++)
            check($sformatf("rd_data%0d", i), 64'(rq[i]), 64'(er[i]));
        if (op != 2'd0) check("wr_drained", 64'(wq.size()), 64'd0);
        check("idle_pins", 64'({tck, tms, tdi, busy}), 64'd0);
    endtask

    task automatic run_cmd(input logic [1:0] op, input int nbits, input logic inv, input bit drop_en);
        tdo_inv = inv;
        issue(op, nbits);
        if (drop_en) enable = 1'b0;
        wait_idle();
        enable = 1'b1;
        check_result(op, nbits, inv);
    endtask

    initial begin
        int t;
        int nb;
        logic [1:0] op;
        rst_n     = 1'b0;
        enable    = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_nbits = '0;
        tdo_inv   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({tck, tms, tdi, cmd_ready, wr_ready, rd_valid, busy}), 64'd0);
        check("reset_rd_data", 64'(rd_data), 64'd0);
        rst_n = 1'b1;

        // RESET op: five TMS=1 pulses, one TMS=0 pulse, 24 clks busy.
        wbuf.delete();
        run_cmd(2'd0, 0, 1'b0, 1'b0);
        check("reset_busy_clks", 64'(busy_clks), 64'd24);

        wbuf.delete(); wbuf.push_back(32'h0000_00A5);
        run_cmd(2'd2, 8, 1'b0, 1'b0);

        wbuf.delete(); wbuf.push_back(32'h1234_5678); wbuf.push_back(32'h0000_00FF);
        run_cmd(2'd3, 40, 1'b0, 1'b0);

        wbuf.delete(); wbuf.push_back(32'h0000_001F);
        run_cmd(2'd1, 6, 1'b0, 1'b0);

        wbuf.delete();
        run_cmd(2'd2, 0, 1'b0, 1'b0);

        // enable low blocks acceptance.
        enable = 1'b0;
        @(negedge clk);
        cmd_op = 2'd2; cmd_nbits = 16'd8; cmd_valid = 1'b1;
        repeat (10) @(negedge clk);
        check("disabled_cmd_ready", 64'(cmd_ready), 64'd0);
        check("disabled_busy", 64'(busy), 64'd0);
        cmd_valid = 1'b0;
        enable    = 1'b1;
        repeat (2) @(negedge clk);

        // Read backpressure stalls TCK after bit 63; a competing command is refused.
        wbuf.delete(); wbuf.push_back($urandom); wbuf.push_back($urandom);
        tdo_inv = 1'b1;
        rd_en   = 1'b0;
        issue(2'd2, 64);
        t = 0;
        while (mq.size() < 64 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        cmd_op = 2'd0; cmd_valid = 1'b1;
        repeat (40) @(negedge clk);
        check("stall_tck_frozen", 64'(mq.size()), 64'd64);
        check("stall_tck_low", 64'(tck), 64'd0);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_rd_valid", 64'(rd_valid), 64'd1);
        check("busy_cmd_ready", 64'(cmd_ready), 64'd0);
        cmd_valid = 1'b0;
        rd_en     = 1'b1;
        wait_idle();
        check_result(2'd2, 64, 1'b1);

        // Randomized commands with read backpressure and enable drops.
        rd_rand = 1'b1;
        for (int it = 0; it < 8; it++) begin
            op = 2'($urandom_range(0, 3));
            nb = $urandom_range(0, 100);
            wbuf.delete();
            for (int w = 0; w < (nb + 31) / 32; w++) wbuf.push_back($urandom);
            run_cmd(op, nb, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end
        rd_rand = 1'b0;

        // Asynchronous reset mid-scan, then a clean command.
        wbuf.delete(); wbuf.push_back($urandom); wbuf.push_back($urandom);
        tdo_inv = 1'b0;
        issue(2'd2, 64);
        t = 0;
        while (mq.size() < 10 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_ctrl", 64'({tck, tms, tdi, cmd_ready, wr_ready, rd_valid, busy}), 64'd0);
        check("midreset_rd_data", 64'(rd_data), 64'd0);
        wq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wbuf.delete(); wbuf.push_back($urandom); wbuf.push_back($urandom);
        run_cmd(2'd3, 45, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
